// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared types and constants for pipeline_stage_register.
//   stage_state_t : occupancy of the stage (EMPTY, ONE = main valid,
//                   FULL = main and skid valid)
//   PERF_CNT_W    : width of the optional performance counters
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one ctrl+data holding register of a pipeline stage.
//   clk     : clock
//   clr     : synchronous clear; ctrl goes to CTRL_CLR, data to zero
//   load    : capture ctrl_d/data_d on the next clock
//   ctrl_d  : control bundle to capture
//   data_d  : data bundle to capture
//   ctrl_q  : held control bundle
//   data_q  : held data bundle
module pipe_slot #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 175,
  parameter logic [CTRL_W-1:0] CTRL_CLR = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      ctrl_q <= CTRL_CLR;
      data_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: valid/ready pipeline stage with a two-entry skid
// buffer and hazard flush, used between the IF/ID/EX/MEM/WB stages.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : kill every held entry (bubble inserted)
//   in_valid      : upstream offers ctrl_in/data_in
//   in_ready      : stage accepts this cycle
//   out_valid     : stage presents a valid instruction
//   out_ready     : downstream accepts; low stalls the stage
//   ctrl_out      : main control bundle, CTRL_BUBBLE whenever not valid
//   data_out      : main data bundle (keeps its last value when empty)
// Optional build macro PIPE_STAGE_PERF_EN adds saturating counters
//   stall_cycles  : cycles with out_valid & !out_ready
//   flush_count   : cycles with flush while the stage held something
//
// state | meaning
// EMPTY | nothing held, ctrl_out shows the bubble
// ONE   | main slot valid
// FULL  | main and skid valid, upstream is held off
module pipeline_stage_register
  import pipe_stage_pkg::*;
#(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 175,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count,
`endif
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [DATA_W-1:0]     data_out
);

  stage_state_t state, state_nxt;

  logic              accept, drain;
  logic              main_load, skid_load, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    in_ready       = !rst && !flush && (state != FULL);
    out_valid      = !rst && (state != EMPTY);
    accept         = in_valid && in_ready;
    drain          = out_valid && out_ready;

    if (flush) begin
      // A concurrent drain is still honoured by the downstream handshake;
      // the slots are left untouched so data_out keeps its last value.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end else if (accept && drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_nxt      = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end

    ctrl_out = out_valid ? main_ctrl : CTRL_BUBBLE;
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_in;
  assign main_data_d = main_from_skid ? skid_data : data_in;
  assign data_out    = main_data;

  pipe_slot #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CTRL_CLR(CTRL_BUBBLE)
  ) u_main (
    .clk   (clk),
    .clr   (rst),
    .load  (main_load),
    .ctrl_d(main_ctrl_d),
    .data_d(main_data_d),
    .ctrl_q(main_ctrl),
    .data_q(main_data)
  );

  pipe_slot #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CTRL_CLR(CTRL_BUBBLE)
  ) u_skid (
    .clk   (clk),
    .clr   (rst),
    .load  (skid_load),
    .ctrl_d(ctrl_in),
    .data_d(data_in),
    .ctrl_q(skid_ctrl),
    .data_q(skid_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1))
        stall_q <= stall_q + PERF_CNT_W'(1);
      if (flush && (state != EMPTY) && (flush_q != '1))
        flush_q <= flush_q + PERF_CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
module tb_pipeline_stage_register;

  localparam int              CW  = 16;
  localparam int              DW  = 175;
  localparam logic [CW-1:0]   BUB = 16'h00F0;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [DW-1:0] data_in, data_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cycles, flush_count;
  logic [31:0]   m_stall, m_flush;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  pipeline_stage_register #(
    .CTRL_W     (CW),
    .DATA_W     (DW),
    .CTRL_BUBBLE(BUB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ctrl_in     (ctrl_in),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cycles(stall_cycles),
    .flush_count (flush_count),
`endif
    .ctrl_out    (ctrl_out),
    .data_out    (data_out)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    ctrl_in  = c;
    data_in  = d;
  endtask

  // One clock: compare outputs against the queue model mid-cycle, then
  // advance the model with the handshake that takes place at the edge.
  task automatic cyc();
    logic          e_ov, e_ir, e_drain, e_acc;
    logic [CW-1:0] e_c;
    #2;
    e_ov = !rst && (mq.size() > 0);
    e_ir = !rst && !flush && (mq.size() < 2);
    e_c  = e_ov ? mq[0].c : BUB;
    chk("out_valid", DW'(out_valid), DW'(e_ov));
    chk("in_ready",  DW'(in_ready),  DW'(e_ir));
    chk("ctrl_out",  DW'(ctrl_out),  DW'(e_c));
    chk("data_out",  data_out,       m_last);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cycles", DW'(stall_cycles), DW'(m_stall));
    chk("flush_count",  DW'(flush_count),  DW'(m_flush));
`endif
    e_drain = e_ov && out_ready;
    e_acc   = in_valid && e_ir;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last = '0;
`ifdef PIPE_STAGE_PERF_EN
      m_stall = '0;
      m_flush = '0;
`endif
    end else begin
`ifdef PIPE_STAGE_PERF_EN
      if (e_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush && mq.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        if (e_drain) void'(mq.pop_front());
        if (e_acc) mq.push_back('{c: ctrl_in, d: data_in});
      end
      if (mq.size() > 0) m_last = mq[0].d;
    end
    #1;
  endtask

  initial begin
    m_last = '0;
`ifdef PIPE_STAGE_PERF_EN
    m_stall = '0;
    m_flush = '0;
`endif
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // streaming, out_ready high: one per cycle, never FULL
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      cyc();
    end
    drive(1'b0, '0, '0);
    cyc(); cyc();

    // backpressure: A, B fill the stage, C waits upstream
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, DW'(10)); cyc();
    drive(1'b1, 16'h000B, DW'(11)); cyc();
    drive(1'b1, 16'h000C, DW'(12)); cyc(); cyc();
    out_ready = 1'b1;
    cyc(); cyc();
    drive(1'b0, '0, '0);
    cyc(); cyc();

    // flush while FULL with a concurrent offer D
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, DW'(20)); cyc();
    drive(1'b1, 16'h000B, DW'(21)); cyc();
    drive(1'b1, 16'h000D, DW'(23)); flush = 1'b1; cyc();
    drive(1'b0, '0, '0); flush = 1'b0; cyc(); cyc();

    // flush concurrent with a drain from ONE
    drive(1'b1, 16'h00AA, DW'(30)); cyc();
    drive(1'b0, '0, '0); out_ready = 1'b1; flush = 1'b1; cyc();
    flush = 1'b0; cyc();

    // stall five cycles in ONE, then flush
    out_ready = 1'b0;
    drive(1'b1, 16'h0055, DW'(40)); cyc();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) cyc();
    out_ready = 1'b1; flush = 1'b1; cyc();
    flush = 1'b0; cyc();

    // reset in the middle of traffic discards entries
    out_ready = 1'b0;
    drive(1'b1, 16'h0077, DW'(50)); cyc(); cyc();
    rst = 1'b1; flush = 1'b1; cyc();
    rst = 1'b0; flush = 1'b0; drive(1'b0, '0, '0); cyc();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom()), rand_data());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; drive(1'b0, '0, '0); out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
